// File: rtl/step_move_sequencer_if.sv
// rtl/step_move_sequencer_if.sv - move command handshake between the SPI decoder and the sequencer
interface step_move_sequencer_if #(
  parameter int COUNT_W  = 16,
  parameter int PERIOD_W = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [COUNT_W-1:0]  cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/step_move_sequencer.sv
// rtl/step_move_sequencer.sv - queued step/dir move player with DIR setup, pulse width and halt handling
module step_move_sequencer #(
  parameter int MOVE_DEPTH = 4,
  parameter int COUNT_W    = 16,
  parameter int PERIOD_W   = 16,
  parameter int PULSE_W    = 2,
  parameter int DIR_SETUP  = 4
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  halt,
  step_move_sequencer_if.slave  cmd,
  output logic                  step_out,
  output logic                  dir_out,
  output logic                  buffer_dtr,
  output logic                  move_done,
  output logic                  busy
);

  localparam int AW = (MOVE_DEPTH > 1) ? $clog2(MOVE_DEPTH) : 1;
  localparam logic [PERIOD_W-1:0] MIN_PE  = PERIOD_W'(PULSE_W + 1);
  localparam logic [PERIOD_W-1:0] HIGH_M1 = PERIOD_W'(PULSE_W - 1);
  localparam logic [PERIOD_W-1:0] SETUP_M1 = PERIOD_W'(DIR_SETUP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DIR_WAIT, S_HIGH, S_LOW, S_DONE
  } state_t;

  logic                dir_mem    [MOVE_DEPTH];
  logic [COUNT_W-1:0]  steps_mem  [MOVE_DEPTH];
  logic [PERIOD_W-1:0] period_mem [MOVE_DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] tim_q, tim_d;
  logic [COUNT_W-1:0]  rem_q, rem_d;
  logic [PERIOD_W-1:0] pe_q, pe_d;
  logic                mv_dir_q, mv_dir_d;
  logic                dir_q, dir_d;
  logic                halt_pend_q, halt_pend_d;
  logic                step_q, done_q;
  logic [PERIOD_W-1:0] head_period, head_pe;

  assign full          = (count_q == (AW+1)'(MOVE_DEPTH));
  assign empty         = (count_q == '0);
  assign cmd.cmd_ready = !full && !halt;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign buffer_dtr    = (count_q <= (AW+1)'(MOVE_DEPTH / 2));

  // A zero or too-short period is stretched so every LOW phase lasts at least one cycle
  assign head_period = period_mem[rd_ptr_q];
  assign head_pe     = (head_period < MIN_PE) ? MIN_PE : head_period;

  always_ff @(posedge CLK) begin
    if (push) begin
      dir_mem[wr_ptr_q]    <= cmd.cmd_dir;
      steps_mem[wr_ptr_q]  <= cmd.cmd_steps;
      period_mem[wr_ptr_q] <= cmd.cmd_period;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (halt) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    tim_d       = tim_q;
    rem_d       = rem_q;
    pe_d        = pe_q;
    mv_dir_d    = mv_dir_q;
    dir_d       = dir_q;
    halt_pend_d = halt_pend_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        halt_pend_d = 1'b0;
        if (enable && !halt && !empty) begin
          pop      = 1'b1;
          mv_dir_d = dir_mem[rd_ptr_q];
          rem_d    = steps_mem[rd_ptr_q];
          pe_d     = head_pe;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (halt) begin
          state_d = S_IDLE;
        end else begin
          dir_d = mv_dir_q;
          if (rem_q == '0) begin
            state_d = S_DONE;
          end else if (mv_dir_q != dir_q) begin
            tim_d   = SETUP_M1;
            state_d = S_DIR_WAIT;
          end else begin
            tim_d   = HIGH_M1;
            state_d = S_HIGH;
          end
        end
      end
      S_DIR_WAIT: begin
        if (halt) begin
          state_d = S_IDLE;
        end else if (tim_q == '0) begin
          tim_d   = HIGH_M1;
          state_d = S_HIGH;
        end else begin
          tim_d = tim_q - 1'b1;
        end
      end
      S_HIGH: begin
        // A halt seen anywhere in the pulse is remembered so the pulse never gets cut short
        if (halt) halt_pend_d = 1'b1;
        if (tim_q == '0) begin
          rem_d = rem_q - 1'b1;
          if (halt || halt_pend_q) begin
            state_d = S_IDLE;
          end else begin
            tim_d   = pe_q - MIN_PE;
            state_d = S_LOW;
          end
        end else begin
          tim_d = tim_q - 1'b1;
        end
      end
      S_LOW: begin
        if (halt) begin
          state_d = S_IDLE;
        end else if (tim_q == '0) begin
          if (rem_q != '0) begin
            tim_d   = HIGH_M1;
            state_d = S_HIGH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          tim_d = tim_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      tim_q       <= '0;
      rem_q       <= '0;
      pe_q        <= MIN_PE;
      mv_dir_q    <= 1'b0;
      dir_q       <= 1'b0;
      halt_pend_q <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tim_q       <= tim_d;
      rem_q       <= rem_d;
      pe_q        <= pe_d;
      mv_dir_q    <= mv_dir_d;
      dir_q       <= dir_d;
      halt_pend_q <= halt_pend_d;
      step_q      <= (state_d == S_HIGH);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign step_out  = step_q;
  assign dir_out   = dir_q;
  assign move_done = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_step_move_sequencer.sv
// tb/tb_step_move_sequencer.sv - directed bench with a move-list reference model for step_move_sequencer
module tb_step_move_sequencer;
  localparam int MOVE_DEPTH = 4;
  localparam int COUNT_W    = 16;
  localparam int PERIOD_W   = 16;
  localparam int PULSE_W    = 2;
  localparam int DIR_SETUP  = 4;

  logic CLK = 1'b0, resetn = 1'b0, enable = 1'b0, halt = 1'b0;
  logic step_out, dir_out, buffer_dtr, move_done, busy;

  step_move_sequencer_if #(.COUNT_W(COUNT_W), .PERIOD_W(PERIOD_W)) cmd_if ();

  step_move_sequencer #(
    .MOVE_DEPTH(MOVE_DEPTH), .COUNT_W(COUNT_W), .PERIOD_W(PERIOD_W),
    .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP)
  ) dut (
    .CLK(CLK), .resetn(resetn), .enable(enable), .halt(halt), .cmd(cmd_if),
    .step_out(step_out), .dir_out(dir_out), .buffer_dtr(buffer_dtr),
    .move_done(move_done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int errs = 0, checks = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {bit dir; int steps; int period;} cmd_t;
  typedef struct packed {logic step; logic done; logic busy; logic dir;} out_t;

  cmd_t mq[$];
  out_t plan[$];
  out_t cur = '0;

  // Reference: each started move is unrolled into the list of per-cycle outputs it must produce
  always @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      plan.delete();
      cur = '0;
    end else begin
      bit   acc;
      cmd_t c;
      out_t keep[$];
      int   pe;
      acc = cmd_if.cmd_valid && (mq.size() < MOVE_DEPTH) && !halt;
      c.dir = cmd_if.cmd_dir;
      c.steps = int'(cmd_if.cmd_steps);
      c.period = int'(cmd_if.cmd_period);
      if (halt) begin
        mq.delete();
        keep = {};
        if (cur.step)
          for (int i = 0; i < plan.size() && plan[i].step; i++) keep.push_back(plan[i]);
        plan = keep;
      end
      if (plan.size() == 0 && !cur.busy && enable && !halt && mq.size() > 0) begin
        cmd_t m;
        m  = mq.pop_front();
        pe = (m.period < PULSE_W + 1) ? PULSE_W + 1 : m.period;
        plan.push_back('{1'b0, 1'b0, 1'b1, cur.dir});
        if (m.steps != 0 && m.dir != cur.dir)
          repeat (DIR_SETUP) plan.push_back('{1'b0, 1'b0, 1'b1, m.dir});
        for (int s = 0; s < m.steps; s++) begin
          repeat (PULSE_W) plan.push_back('{1'b1, 1'b0, 1'b1, m.dir});
          repeat (pe - PULSE_W) plan.push_back('{1'b0, 1'b0, 1'b1, m.dir});
        end
        plan.push_back('{1'b0, 1'b1, 1'b1, m.dir});
      end
      if (acc) mq.push_back(c);
      if (plan.size() > 0) cur = plan.pop_front();
      else cur = '{1'b0, 1'b0, 1'b0, cur.dir};
    end
  end

  always @(negedge CLK) begin
    chk("step_out", step_out, cur.step);
    chk("dir_out", dir_out, cur.dir);
    chk("move_done", move_done, cur.done);
    chk("busy", busy, cur.busy);
    chk("cmd_ready", cmd_if.cmd_ready, (mq.size() < MOVE_DEPTH) && !halt);
    chk("buffer_dtr", buffer_dtr, mq.size() <= MOVE_DEPTH / 2);
  end

  task automatic push(input bit d, input int st, input int per, output int acc);
    cmd_if.cmd_dir    = d;
    cmd_if.cmd_steps  = st[COUNT_W-1:0];
    cmd_if.cmd_period = per[PERIOD_W-1:0];
    cmd_if.cmd_valid  = 1'b1;
    acc = -1;
    for (int i = 0; i < 1000 && acc < 0; i++) begin
      @(negedge CLK);
      if (cmd_if.cmd_ready) acc = cyc + 1;
      @(posedge CLK);
      #1;
    end
    cmd_if.cmd_valid = 1'b0;
    if (acc < 0) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic at_cyc(input int c);
    do @(negedge CLK); while (cyc < c);
    chk("at_cycle", cyc, c);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 2000 && (plan.size() != 0 || cur.busy || mq.size() != 0)) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("idle_timeout", n < 2000, 1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int k, a2, a3, a4, a5, a6, h;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_dir = 1'b0;
    cmd_if.cmd_steps = '0;   cmd_if.cmd_period = '0;
    @(negedge CLK);
    chk("rst_step", step_out, 0);  chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_if.cmd_ready, 1); chk("rst_dtr", buffer_dtr, 1);
    #2 resetn = 1'b1;
    @(posedge CLK); #1 enable = 1'b1;

    // basic move, dir unchanged
    push(1'b0, 3, 10, k);
    at_cyc(k + 1);  chk("t1_load_busy", busy, 1); chk("t1_load_step", step_out, 0);
    at_cyc(k + 2);  chk("t1_rise", step_out, 1);
    at_cyc(k + 3);  chk("t1_high2", step_out, 1);
    at_cyc(k + 4);  chk("t1_fall", step_out, 0);
    at_cyc(k + 11); chk("t1_low_end", step_out, 0);
    at_cyc(k + 12); chk("t1_rise2", step_out, 1);
    at_cyc(k + 31); chk("t1_pre_done", move_done, 0);
    at_cyc(k + 32); chk("t1_done", move_done, 1); chk("t1_dir", dir_out, 0);
    at_cyc(k + 33); chk("t1_done_once", move_done, 0); chk("t1_idle", busy, 0);
    wait_idle();

    // direction change inserts setup time
    push(1'b1, 2, 6, k);
    at_cyc(k + 1);  chk("t2_load_dir", dir_out, 0);
    at_cyc(k + 2);  chk("t2_dir", dir_out, 1); chk("t2_nostep", step_out, 0);
    at_cyc(k + 5);  chk("t2_setup", step_out, 0);
    at_cyc(k + 6);  chk("t2_rise", step_out, 1);
    at_cyc(k + 12); chk("t2_rise2", step_out, 1);
    at_cyc(k + 18); chk("t2_done", move_done, 1);
    wait_idle();

    // zero-step move
    push(1'b0, 0, 5, k);
    at_cyc(k + 1);  chk("t5_busy", busy, 1);
    at_cyc(k + 2);  chk("t5_done", move_done, 1); chk("t5_dir", dir_out, 0);
    at_cyc(k + 3);  chk("t5_idle", busy, 0);
    wait_idle();

    // queue fill, backpressure and buffer_dtr hysteresis points
    push(1'b0, 3, 40, k);
    push(1'b1, 1, 3, a2);
    push(1'b0, 2, 3, a3);
    push(1'b1, 1, 3, a4);
    push(1'b0, 1, 4, a5);
    push(1'b0, 1, 3, a6);
    chk("t3_a2", a2, k + 1); chk("t3_a5", a5, k + 4);
    chk("t3_a6_held", a6, k + 125);
    at_cyc(k + 125); chk("t3_full_ready", cmd_if.cmd_ready, 0); chk("t3_full_dtr", buffer_dtr, 0);
    at_cyc(k + 135); chk("t3_occ3_dtr", buffer_dtr, 0); chk("t3_occ3_ready", cmd_if.cmd_ready, 1);
    at_cyc(k + 148); chk("t3_occ2_dtr", buffer_dtr, 1);
    wait_idle();

    // halt during the first cycle of a pulse with two moves queued
    push(1'b0, 5, 20, k);
    push(1'b0, 1, 3, a2);
    push(1'b0, 1, 3, a3);
    for (int i = 0; i < 50 && !step_out; i++) begin @(posedge CLK); #1; end
    halt = 1'b1;
    h = cyc;
    at_cyc(h);     chk("t4_high1", step_out, 1); chk("t4_ready", cmd_if.cmd_ready, 0);
    at_cyc(h + 1); chk("t4_high2", step_out, 1);
    at_cyc(h + 2); chk("t4_fall", step_out, 0); chk("t4_idle", busy, 0); chk("t4_nodone", move_done, 0);
    at_cyc(h + 6); chk("t4_quiet", step_out, 0); chk("t4_dtr", buffer_dtr, 1);
    @(posedge CLK); #1 halt = 1'b0;
    at_cyc(h + 12); chk("t4_resume_ready", cmd_if.cmd_ready, 1); chk("t4_flushed", busy, 0);
    wait_idle();

    // minimum period, then asynchronous reset mid-pulse
    push(1'b0, 4, 0, k);
    push(1'b1, 2, 5, a2);
    at_cyc(k + 2); chk("t6_rise", step_out, 1);
    at_cyc(k + 4); chk("t6_low", step_out, 0);
    at_cyc(k + 5); chk("t6_rise2", step_out, 1);
    at_cyc(k + 8); chk("t6_mid_pulse", step_out, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_step", step_out, 0); chk("t6_async_busy", busy, 0);
    chk("t6_async_dir", dir_out, 0);   chk("t6_async_dtr", buffer_dtr, 1);
    @(negedge CLK); #2 resetn = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    at_cyc(cyc); chk("t6_post_busy", busy, 0); chk("t6_post_ready", cmd_if.cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
